// File: rtl/ins_ram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ins_ram_loader_pkg
// Purpose  : Shared types for the instruction RAM loader: FSM state encoding,
//            error codes and the width of the length/byte-count datapath.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ins_ram_loader_pkg;

  // 9 bits so that a full 256-byte image length is representable.
  localparam int LEN_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN    = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_VERIFY = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_VERIFY  = 2'd3
  } err_e;

endpackage
`default_nettype wire

// File: rtl/ins_ram_loader_rx_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : ins_ram_loader_rx_timeout_ctr
// Purpose  : Inter-byte silence counter for the loader.
// Ports    : clk     - system clock
//            rst     - asynchronous active-high reset
//            clr     - restart the count (new phase or byte accepted)
//            en      - count enable (loader waiting for rx bytes)
//            expired - counter is about to reach TIMEOUT_CYC-1
// Revision : 1.0 - initial release
// ============================================================================
module ins_ram_loader_rx_timeout_ctr #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // expired fires on the cycle whose edge would take the count to
  // TIMEOUT_CYC-1, so the registered error in the FSM appears exactly
  // TIMEOUT_CYC-1 cycles after the last accepted byte.
  localparam logic [TO_W-1:0] C_LAST = TO_W'(TIMEOUT_CYC - 2);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != C_LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && !clr && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/ins_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : ins_ram_loader
// Purpose  : Loads an instruction image from a UART byte stream
//            (length, N data bytes, checksum) into the 256x8 instruction RAM
//            through port B, reads it back to verify, and holds the processor
//            in reset until a verified image is present.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            start              - pulse to arm a new load
//            rx_data, rx_valid  - byte stream from the UART receiver
//            q_b                - RAM port-B read data (1-cycle latency)
//            addr_b/data_b/we_b - RAM port-B address / write data / write enable
//            busy               - load or verify in progress
//            proc_hold          - processor reset request
//            load_done/load_err - verified image / failed load
//            err_code           - 0 none, 1 timeout, 2 checksum, 3 readback
//            byte_count         - data bytes written in the current load
// Revision : 1.0 - initial release
// ============================================================================
module ins_ram_loader
  import ins_ram_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic [7:0]       q_b,
  output logic [7:0]       addr_b,
  output logic [7:0]       data_b,
  output logic             we_b,
  output logic             busy,
  output logic             proc_hold,
  output logic             load_done,
  output logic             load_err,
  output logic [1:0]       err_code,
  output logic [LEN_W-1:0] byte_count
);

  state_e           state_q, state_d;
  err_e             err_code_q, err_code_d;
  logic [7:0]       addr_q, addr_d;          // next write address
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] vcnt_q, vcnt_d;          // read addresses issued
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       vsum_q, vsum_d;
  logic             issue_q, issue_d;        // addr_b_q is a live read address
  logic             rd_vld_q, rd_vld_d;      // q_b carries read data this cycle
  logic [7:0]       addr_b_q, addr_b_d;
  logic [7:0]       data_b_q, data_b_d;
  logic             we_b_q, we_b_d;
  logic             busy_q, busy_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             to_clr, to_en, to_expired;

  ins_ram_loader_rx_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    vcnt_d     = vcnt_q;
    sum_d      = sum_q;
    vsum_d     = vsum_q;
    issue_d    = 1'b0;
    rd_vld_d   = issue_q;
    addr_b_d   = addr_b_q;
    data_b_d   = data_b_q;
    we_b_d     = 1'b0;
    busy_d     = busy_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    to_clr     = 1'b0;
    to_en      = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          cnt_d      = '0;
          sum_d      = '0;
          hold_d     = 1'b1;
          busy_d     = 1'b1;
          to_clr     = 1'b1;
        end
      end
      ST_LEN: begin
        if (rx_valid) begin
          to_clr  = 1'b1;
          len_d   = (rx_data == 8'd0) ? LEN_W'(256) : {1'b0, rx_data};
          addr_d  = '0;
          state_d = ST_DATA;
        end else if (to_expired) begin
          state_d    = ST_ERR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          busy_d     = 1'b0;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          to_clr   = 1'b1;
          we_b_d   = 1'b1;
          addr_b_d = addr_q;
          data_b_d = rx_data;
          addr_d   = addr_q + 8'd1;
          sum_d    = sum_q + rx_data;
          cnt_d    = cnt_q + LEN_W'(1);
          if ((cnt_q + LEN_W'(1)) == len_q) begin
            state_d = ST_CSUM;
          end
        end else if (to_expired) begin
          state_d    = ST_ERR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          busy_d     = 1'b0;
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          to_clr = 1'b1;
          if (rx_data == sum_q) begin
            // Issue read address 0 on entry so VERIFY spans exactly len+2 cycles.
            state_d  = ST_VERIFY;
            addr_b_d = '0;
            issue_d  = 1'b1;
            vcnt_d   = LEN_W'(1);
            vsum_d   = '0;
          end else begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
            busy_d     = 1'b0;
          end
        end else if (to_expired) begin
          state_d    = ST_ERR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          busy_d     = 1'b0;
        end
      end
      ST_VERIFY: begin
        if (rd_vld_q) begin
          vsum_d = vsum_q + q_b;
        end
        if (vcnt_q < len_q) begin
          addr_b_d = vcnt_q[7:0];
          issue_d  = 1'b1;
          vcnt_d   = vcnt_q + LEN_W'(1);
        end else if (!issue_q && !rd_vld_q) begin
          // All read data has been folded into vsum_q.
          busy_d = 1'b0;
          if (vsum_q == sum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_VERIFY;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      err_code_q <= ERR_NONE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      vcnt_q     <= '0;
      sum_q      <= '0;
      vsum_q     <= '0;
      issue_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      addr_b_q   <= '0;
      data_b_q   <= '0;
      we_b_q     <= 1'b0;
      busy_q     <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      vcnt_q     <= vcnt_d;
      sum_q      <= sum_d;
      vsum_q     <= vsum_d;
      issue_q    <= issue_d;
      rd_vld_q   <= rd_vld_d;
      addr_b_q   <= addr_b_d;
      data_b_q   <= data_b_d;
      we_b_q     <= we_b_d;
      busy_q     <= busy_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign addr_b     = addr_b_q;
  assign data_b     = data_b_q;
  assign we_b       = we_b_q;
  assign busy       = busy_q;
  assign proc_hold  = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign err_code   = err_code_q;
  assign byte_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ins_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_ram_loader
// Purpose  : Self-checking bench for ins_ram_loader with a 256x8 RAM model on
//            port B. Expected writes and load outcomes come from the image
//            bytes fed in (byte positions, mod-256 sum, length rules).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_ram_loader;

  localparam int T_CYC = 1000;

  logic       clk = 1'b0;
  logic       rst, start, rx_valid, fault;
  logic [7:0] rx_data, q_b, ram_q;
  logic [7:0] addr_b, data_b;
  logic       we_b, busy, proc_hold, load_done, load_err;
  logic [1:0] err_code;
  logic [8:0] byte_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] ram [256];
  logic [7:0] img [$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         due;
  } wr_t;
  wr_t expq [$];

  ins_ram_loader #(.TIMEOUT_CYC(T_CYC), .TO_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .q_b        (q_b),
    .addr_b     (addr_b),
    .data_b     (data_b),
    .we_b       (we_b),
    .busy       (busy),
    .proc_hold  (proc_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .err_code   (err_code),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we_b) ram[addr_b] <= data_b;
    ram_q <= ram[addr_b];
  end
  assign q_b = ram_q | {7'b0, fault};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle: a write must appear exactly one cycle after each data byte,
  // at that byte's position, and nowhere else.
  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0].due == cyc) begin
      check("we_b_pulse", {31'd0, we_b}, 32'd1);
      check("we_addr", {24'd0, addr_b}, {24'd0, expq[0].a});
      check("we_data", {24'd0, data_b}, {24'd0, expq[0].d});
      void'(expq.pop_front());
    end else begin
      check("no_stray_we", {31'd0, we_b}, 32'd0);
    end
    check("hold_vs_done", {31'd0, proc_hold}, {31'd0, !load_done});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit is_data, input logic [7:0] a);
    rx_data  = b;
    rx_valid = 1'b1;
    if (is_data) expq.push_back('{a, b, cyc + 1});
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr_b"}, {24'd0, addr_b}, 32'd0);
    check({tag, "_data_b"}, {24'd0, data_b}, 32'd0);
    check({tag, "_we_b"}, {31'd0, we_b}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold"}, {31'd0, proc_hold}, 32'd1);
    check({tag, "_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_err"}, {31'd0, load_err}, 32'd0);
    check({tag, "_code"}, {30'd0, err_code}, 32'd0);
    check({tag, "_count"}, {23'd0, byte_count}, 32'd0);
  endtask

  // Feed a whole load from img and check the outcome the stream implies.
  task automatic load(input string tag, input logic [7:0] lenb, input logic [7:0] csum,
                      input bit flt, input bit poke_start);
    int         n;
    int         vc;
    int         mism;
    int         exp_err;
    logic [7:0] msum;
    n    = (lenb == 8'd0) ? 256 : int'(lenb);
    msum = 8'd0;
    for (int i = 0; i < n; i++) msum = msum + img[i];
    exp_err = (csum != msum) ? 2 : (flt ? 3 : 0);
    pulse_start();
    send(lenb, 1'b0, 8'd0);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = i[7:0];
      send(img[i], 1'b1, a);
      if (poke_start && i == 0) pulse_start();
    end
    send(csum, 1'b0, 8'd0);
    fault = flt;
    vc = 0;
    forever begin
      @(negedge clk);
      if (!busy || vc > 600) break;
      vc++;
    end
    fault = 1'b0;
    check({tag, "_verify_cycles"}, vc, (exp_err == 2) ? 0 : n + 2);
    check({tag, "_done"}, {31'd0, load_done}, {31'd0, exp_err == 0});
    check({tag, "_err"}, {31'd0, load_err}, {31'd0, exp_err != 0});
    check({tag, "_code"}, {30'd0, err_code}, exp_err);
    check({tag, "_count"}, {23'd0, byte_count}, n);
    check({tag, "_hold"}, {31'd0, proc_hold}, {31'd0, exp_err != 0});
    mism = 0;
    for (int i = 0; i < n; i++) if (ram[i] !== img[i]) mism++;
    check({tag, "_ram_image"}, mism, 0);
    tick();
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; fault = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'd0;
    tick(3);
    check_reset_vals("reset");
    rst = 1'b0;
    tick(2);

    // 1: normal load, back-to-back bytes
    img = '{8'h11, 8'h22, 8'h33};
    load("t1", 8'h03, 8'h66, 1'b0, 1'b0);
    check("t1_ram1_lit", {24'd0, ram[1]}, 32'h22);
    check("t1_done_lit", {31'd0, load_done}, 32'd1);

    // 2: bad checksum
    img = '{8'hAA, 8'hBB};
    load("t2", 8'h02, 8'h00, 1'b0, 1'b0);
    check("t2_code_lit", {30'd0, err_code}, 32'd2);

    // 3: full 256-byte image, length byte 0
    img = {};
    for (int i = 0; i < 256; i++) img.push_back(i[7:0]);
    load("t3", 8'h00, 8'h80, 1'b0, 1'b0);
    check("t3_count_lit", {23'd0, byte_count}, 32'd256);
    check("t3_ram255_lit", {24'd0, ram[255]}, 32'hFF);

    // 4: timeout after one data byte
    pulse_start();
    send(8'h04, 1'b0, 8'd0);
    send(8'h01, 1'b1, 8'd0);
    k = 0;
    forever begin
      @(negedge clk);
      if (load_err || k > T_CYC + 10) break;
      k++;
    end
    check("t4_timeout_latency", k, T_CYC - 1);
    check("t4_code", {30'd0, err_code}, 32'd1);
    check("t4_count", {23'd0, byte_count}, 32'd1);
    check("t4_hold", {31'd0, proc_hold}, 32'd1);
    tick(5);

    // 5: readback fault forced on q_b bit 0
    img = '{8'h10, 8'h20, 8'h30};
    load("t5", 8'h02 + 8'h01, 8'h60, 1'b1, 1'b0);
    check("t5_code_lit", {30'd0, err_code}, 32'd3);

    // 6: async reset mid-DATA, rx in IDLE, start while busy
    pulse_start();
    send(8'h03, 1'b0, 8'd0);
    send(8'hAA, 1'b1, 8'd0);
    send(8'hBB, 1'b1, 8'd1);
    tick(2);
    #2 rst = 1'b1;
    #1 check_reset_vals("t6_rst");
    tick();
    rst = 1'b0;
    tick();
    send(8'h55, 1'b0, 8'd0);
    tick(2);
    check("t6_idle_busy", {31'd0, busy}, 32'd0);
    check("t6_idle_count", {23'd0, byte_count}, 32'd0);
    img = '{8'h01, 8'h02};
    load("t6", 8'h02, 8'h03, 1'b0, 1'b1);
    check("t6_ram0_lit", {24'd0, ram[0]}, 32'h01);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
